// File: rtl/cpu_bus_unit.sv
// CPU-side memory bus sequencer: latches address/store data from the control unit, runs one read or write.
// Optional wait-state timeout is enabled with `define BUS_WAIT_TIMEOUT_EN.
module cpu_bus_unit #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16
) (
    input  logic              i_Clk,
    input  logic              i_Reset_n,
    input  logic              i_Address_Out,
    input  logic              i_Bus_In,
    input  logic              i_Bus_Out,
    input  logic [ADDR_W-1:0] i_Address,
    input  logic [DATA_W-1:0] i_Data_Internal,
    output logic [DATA_W-1:0] o_Data_Internal,
    output logic              o_Data_Valid,
    output logic [ADDR_W-1:0] o_Mem_Addr,
    output logic              o_Mem_Rd,
    output logic              o_Mem_Wr,
    output logic [DATA_W-1:0] o_Mem_Wdata,
    input  logic [DATA_W-1:0] i_Mem_Rdata,
    input  logic              i_Mem_Wait,
    output logic              o_Stall,
    output logic              o_Bus_Error
);

    typedef enum logic [1:0] {IDLE, ADDR_HELD, READ, WRITE} state_t;

    state_t            state_q, state_d;
    logic              addr_ld, wdata_ld, rdata_ld, valid_d, err_d;
    logic [DATA_W-1:0] rdata_d;

`ifdef BUS_WAIT_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       timeout;

    // Fires on the 255th consecutive stalled edge, i.e. as the counter would reach 255.
    assign timeout = i_Mem_Wait && (wait_cnt == 8'd254);
`endif

    always_comb begin
        state_d  = state_q;
        addr_ld  = 1'b0;
        wdata_ld = 1'b0;
        rdata_ld = 1'b0;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        rdata_d  = i_Mem_Rdata;
        case (state_q)
            IDLE: begin
                if (i_Address_Out) begin
                    addr_ld = 1'b1;
                    state_d = ADDR_HELD;
                end
            end
            ADDR_HELD: begin
                // Any bus strobe takes priority over an address re-latch.
                if (i_Bus_In && i_Bus_Out) begin
                    err_d = 1'b1;
                end else if (i_Bus_In) begin
                    state_d = READ;
                end else if (i_Bus_Out) begin
                    wdata_ld = 1'b1;
                    state_d  = WRITE;
                end else if (i_Address_Out) begin
                    addr_ld = 1'b1;
                end
            end
            READ: begin
                if (!i_Mem_Wait) begin
                    rdata_ld = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = IDLE;
                end
`ifdef BUS_WAIT_TIMEOUT_EN
                else if (timeout) begin
                    rdata_ld = 1'b1;
                    rdata_d  = '1;
                    valid_d  = 1'b1;
                    err_d    = 1'b1;
                    state_d  = IDLE;
                end
`endif
            end
            WRITE: begin
                if (!i_Mem_Wait) begin
                    state_d = IDLE;
                end
`ifdef BUS_WAIT_TIMEOUT_EN
                else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q         <= IDLE;
            o_Mem_Addr      <= '0;
            o_Mem_Wdata     <= '0;
            o_Data_Internal <= '0;
            o_Data_Valid    <= 1'b0;
            o_Bus_Error     <= 1'b0;
        end else begin
            state_q      <= state_d;
            o_Data_Valid <= valid_d;
            o_Bus_Error  <= err_d;
            if (addr_ld)  o_Mem_Addr      <= i_Address;
            if (wdata_ld) o_Mem_Wdata     <= i_Data_Internal;
            if (rdata_ld) o_Data_Internal <= rdata_d;
        end
    end

`ifdef BUS_WAIT_TIMEOUT_EN
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            wait_cnt <= '0;
        end else if ((state_q == READ || state_q == WRITE) && i_Mem_Wait) begin
            wait_cnt <= wait_cnt + 8'd1;
        end else begin
            wait_cnt <= '0;
        end
    end
`endif

    // Strobes decode straight from state so reset drops them without a clock edge.
    assign o_Mem_Rd = (state_q == READ);
    assign o_Mem_Wr = (state_q == WRITE);
    assign o_Stall  = (o_Mem_Rd | o_Mem_Wr) & i_Mem_Wait;

endmodule

// File: doc/cpu_bus_unit.md
CPU_BUS_UNIT -- requirements
Module: cpu_bus_unit

Interface
REQ-001 The clock port SHALL be i_Clk  input  1  (single clock; all state updates on its rising edge).
REQ-002 The reset port SHALL be i_Reset_n  input  1  (asynchronous, active-low reset).
REQ-003 The port list SHALL include i_Address_Out  input  1  (control-unit strobe: latch the 16-bit address bus).
REQ-004 The port list SHALL include i_Bus_In  input  1  (control-unit strobe: memory read into the internal 8-bit write bus).
REQ-005 The port list SHALL include i_Bus_Out  input  1  (control-unit strobe: internal 8-bit read bus written to memory).
REQ-006 The port list SHALL include i_Address  input  16  (16-bit register read bus, e.g. HL/PC).
REQ-007 The port list SHALL include i_Data_Internal  input  8  (8-bit register read bus, store data).
REQ-008 The port list SHALL include o_Data_Internal  output  8  (read data toward the register write bus).
REQ-009 The port list SHALL include o_Data_Valid  output  1  (one-cycle pulse when o_Data_Internal is updated).
REQ-010 The port list SHALL include o_Mem_Addr  output  16  (external address).
REQ-011 The port list SHALL include o_Mem_Rd and o_Mem_Wr, each  output  1  (external read and write strobes).
REQ-012 The port list SHALL include o_Mem_Wdata  output  8  (external write data).
REQ-013 The port list SHALL include i_Mem_Rdata  input  8  (external read data).
REQ-014 The port list SHALL include i_Mem_Wait  input  1  (external stall request).
REQ-015 The port list SHALL include o_Stall  output  1  (hold the cycle step).
REQ-016 The port list SHALL include o_Bus_Error  output  1  (one-cycle error pulse).

Function
REQ-017 The FSM SHALL have exactly four states: IDLE, ADDR_HELD, READ, WRITE.
REQ-018 In IDLE with i_Address_Out=1, the unit SHALL latch i_Address into o_Mem_Addr at the edge and go to ADDR_HELD.
REQ-019 In IDLE, i_Bus_In and i_Bus_Out SHALL be ignored with no state change and no memory strobe.
REQ-020 In ADDR_HELD with i_Bus_In=1 and i_Bus_Out=0, the unit SHALL go to READ and drive o_Mem_Rd=1 from the next cycle.
REQ-021 In ADDR_HELD with i_Bus_Out=1 and i_Bus_In=0, the unit SHALL latch i_Data_Internal into o_Mem_Wdata, go to WRITE, and drive o_Mem_Wr=1 from the next cycle.
REQ-022 In ADDR_HELD with i_Bus_In=1 and i_Bus_Out=1 (illegal (HL),(HL) transfer), the unit SHALL pulse o_Bus_Error for one cycle, stay in ADDR_HELD, and drive no strobe.
REQ-023 In ADDR_HELD with i_Address_Out=1 and no bus strobe, the unit SHALL re-latch o_Mem_Addr and stay in ADDR_HELD.
REQ-024 If a bus strobe and i_Address_Out coincide in ADDR_HELD, the bus strobe SHALL win and the address SHALL NOT change.
REQ-025 In READ, at each edge with i_Mem_Wait=0, the unit SHALL capture i_Mem_Rdata into o_Data_Internal, pulse o_Data_Valid for one cycle, and return to IDLE; o_Mem_Rd SHALL drop that edge.
REQ-026 In WRITE, at the first edge with i_Mem_Wait=0, the unit SHALL return to IDLE and drop o_Mem_Wr.
REQ-027 o_Stall SHALL equal (o_Mem_Rd | o_Mem_Wr) & i_Mem_Wait, computed combinationally.
REQ-028 While in READ or WRITE, the unit SHALL ignore all control-unit strobes.
REQ-029 With zero wait, a read SHALL complete in 2 edges after the i_Bus_In edge (Rd high for exactly 1 cycle); each wait cycle SHALL add 1 edge.
REQ-030 o_Mem_Rd and o_Mem_Wr SHALL never be high in the same cycle.
REQ-031 o_Mem_Addr and o_Mem_Wdata SHALL hold stable for the whole of READ or WRITE.

Reset
REQ-032 On i_Reset_n=0, the unit SHALL immediately, without waiting for a clock edge, enter IDLE and clear o_Mem_Addr=16'h0000, o_Mem_Wdata=8'h00, o_Data_Internal=8'h00, o_Data_Valid=0, o_Mem_Rd=0, o_Mem_Wr=0, and o_Bus_Error=0.
REQ-033 If reset asserts mid-READ or mid-WRITE, the transaction SHALL be abandoned with no o_Data_Valid pulse.
REQ-034 The first edge after reset release SHALL be evaluated from IDLE.

Configuration
REQ-035 With macro BUS_WAIT_TIMEOUT_EN defined, an 8-bit wait counter SHALL clear on entry to READ/WRITE and increment per stalled cycle.
REQ-036 With BUS_WAIT_TIMEOUT_EN defined, when the counter reaches 255 with i_Mem_Wait still 1, the unit SHALL abort to IDLE, drop strobes, and pulse o_Bus_Error; an aborted read SHALL also load o_Data_Internal=8'hFF and pulse o_Data_Valid.
REQ-037 Without BUS_WAIT_TIMEOUT_EN, the unit SHALL wait indefinitely, and no counter logic SHALL be present.

Verification
REQ-038 The bench SHALL check: Address_Out with i_Address=16'hC123, then Bus_In, Wait=0, Rdata=8'h5A -> Mem_Addr=C123, Rd high 1 cycle, o_Data_Internal=5A, Data_Valid 1 pulse.
REQ-039 The bench SHALL check: Address_Out with 16'h8000, then Bus_Out with i_Data_Internal=8'h3C, Wait=1 for 3 cycles -> Wr high 4 cycles, Wdata=3C, Stall high 3 cycles.
REQ-040 The bench SHALL check: Bus_In and Bus_Out together in ADDR_HELD -> Bus_Error pulse, no Rd/Wr, state stays ADDR_HELD.
REQ-041 The bench SHALL check: Bus_In in IDLE (no prior Address_Out) -> no strobe and no Data_Valid.
REQ-042 The bench SHALL check: reset asserted during READ with Wait=1 -> Rd=0 immediately, Mem_Addr=0000, no Data_Valid after release.
REQ-043 The bench SHALL check, with BUS_WAIT_TIMEOUT_EN defined: read with Wait held high -> abort after 255 stalled cycles, Bus_Error pulse, o_Data_Internal=FF.
